// File: rtl/cskip_pkg.sv
// Shared types and defaults for the multi-precision carry-skip add sequencer.
package cskip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CHUNK_DEFAULT  = 12;
  localparam int unsigned NCHUNK_DEFAULT = 4;

endpackage

// File: rtl/cskip_chunk_add.sv
// Combinational CHUNK-bit carry-skip adder: 4-bit ripple blocks, each bypassed by a skip mux
// when every bit in the block propagates.
module cskip_chunk_add #(
  parameter int unsigned CHUNK = 12
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned NBLK = CHUNK / 4;

  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    logic c_run;
    logic c_blk_in;
    logic c_rip;
    o_sum    = '0;
    c_run    = i_cin;
    c_blk_in = 1'b0;
    c_rip    = 1'b0;
    for (int unsigned blk = 0; blk < NBLK; blk++) begin
      c_blk_in = c_run;
      c_rip    = c_run;
      for (int unsigned j = 0; j < 4; j++) begin
        o_sum[blk*4+j] = w_p[blk*4+j] ^ c_rip;
        c_rip          = w_g[blk*4+j] | (w_p[blk*4+j] & c_rip);
      end
      // A fully propagating block passes its carry-in straight through.
      c_run = (&w_p[blk*4 +: 4]) ? c_blk_in : c_rip;
    end
    o_cout = c_run;
  end

endmodule

// File: rtl/cskip_mp_add_seq.sv
// Multi-precision add sequencer: streams wide operands through one shared chunk adder,
// LSB slice first, with a carry register linking consecutive slices.
module cskip_mp_add_seq
  import cskip_pkg::*;
#(
  parameter int unsigned CHUNK  = CHUNK_DEFAULT,
  parameter int unsigned NCHUNK = NCHUNK_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [CHUNK*NCHUNK-1:0] i_add_term1,
  input  logic [CHUNK*NCHUNK-1:0] i_add_term2,
  input  logic                    i_cin,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [CHUNK*NCHUNK-1:0] o_sum,
  output logic                    o_cout,
  output logic                    o_busy
);

  localparam int unsigned W  = CHUNK * NCHUNK;
  localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;

  logic [CHUNK-1:0] w_slice_a;
  logic [CHUNK-1:0] w_slice_b;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;

  assign w_slice_a = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_slice_b = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_last    = (r_cnt == CW'(NCHUNK - 1));

  cskip_chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_valid && o_ready) begin
            r_a     <= i_add_term1;
            r_b     <= i_add_term2;
            r_carry <= i_cin;
            r_cnt   <= '0;
            o_sum   <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          o_sum[r_cnt*CHUNK +: CHUNK] <= w_slice_sum;
          r_carry                     <= w_slice_cout;
          if (w_last) begin
            r_cnt   <= '0;
            o_cout  <= w_slice_cout;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cskip_mp_add_seq.sv
// Self-checking bench for cskip_mp_add_seq: directed vector table, handshake corner
// sequences and a randomised scoreboard run with output back-pressure.
module tb_cskip_mp_add_seq;

  localparam int unsigned CHUNK  = 12;
  localparam int unsigned NCHUNK = 4;
  localparam int unsigned W      = CHUNK * NCHUNK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_add_term1;
  logic [W-1:0] i_add_term2;
  logic         i_cin;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_busy;

  logic rdy_val;
  logic bp_en;
  logic r_bp;

  int checks;
  int failures;
  int cyc;
  int n_results;
  int n_pushed;

  logic [W:0] sb_q[$];
  vec_t       vecs[6];

  assign i_ready = bp_en ? r_bp : rdy_val;

  cskip_mp_add_seq #(
    .CHUNK  (CHUNK),
    .NCHUNK (NCHUNK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_add_term1 (i_add_term1),
    .i_add_term2 (i_add_term2),
    .i_cin       (i_cin),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_busy      (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    r_bp = 1'b1;
    forever begin
      @(posedge clk);
      #1 r_bp = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard side: results are popped on the cycle the output handshake completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid || o_busy) chk("ready_low_when_busy", 64'(o_ready), 64'd0);
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = sb_q.pop_front();
          chk("result_sum", 64'(o_sum), 64'(e[W-1:0]));
          chk("result_cout", 64'(o_cout), 64'(e[W]));
          n_results++;
        end
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Presents one operand pair and returns #2 after the accepting edge.
  task automatic send(input logic [W-1:0] a, b, input logic c, input bit push,
                      input logic [W:0] exp);
    int n;
    i_add_term1 = a;
    i_add_term2 = b;
    i_cin       = c;
    i_valid     = 1'b1;
    n = 0;
    while (!o_ready && n < 300) begin
      step();
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      i_valid = 1'b0;
      return;
    end
    if (push) begin
      sb_q.push_back(exp);
      n_pushed++;
    end
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_valid) && n < bound) begin
      step();
      n++;
    end
    if (sb_q.size() != 0 || o_valid) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    int r0;
    int accepts;
    int acc_cyc[2];
    int seen;
    logic [63:0] t64;
    logic [W-1:0] ra, rb;
    logic rc;

    checks = 0; failures = 0; cyc = 0; n_results = 0; n_pushed = 0;
    rst = 1'b1; i_valid = 1'b0; i_add_term1 = '0; i_add_term2 = '0; i_cin = 1'b0;
    rdy_val = 1'b1; bp_en = 1'b0;

    vecs[0] = '{48'h000000000FFF, 48'h000000000001, 1'b0, 48'h000000001000, 1'b0};
    vecs[1] = '{48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, 48'h000000000000, 1'b1};
    vecs[2] = '{48'h000000000000, 48'h000000000000, 1'b1, 48'h000000000001, 1'b0};
    vecs[3] = '{48'h123456789ABC, 48'h0FEDCBA98765, 1'b0, 48'h222222222221, 1'b0};
    vecs[4] = '{48'h800000000000, 48'h800000000000, 1'b0, 48'h000000000000, 1'b1};
    vecs[5] = '{48'hFFF000FFF000, 48'h001000001000, 1'b0, 48'h000001000000, 1'b1};

    step();
    step();
    rst = 1'b0;
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_sum", 64'(o_sum), 64'd0);
    chk("reset_cout", 64'(o_cout), 64'd0);

    // Directed table, i_ready high; also checks accept-to-valid latency.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, {vecs[i].cout, vecs[i].sum});
      chk("busy_after_accept", 64'(o_busy), 64'd1);
      n = 0;
      while (!o_valid && n < 20) begin
        step();
        n++;
      end
      chk("valid_latency", 64'(n), 64'(NCHUNK));
      wait_empty(50);
    end

    // Output back-pressure: result must hold while i_ready is low.
    rdy_val = 1'b0;
    send(vecs[3].a, vecs[3].b, vecs[3].cin, 1'b1, {vecs[3].cout, vecs[3].sum});
    for (int i = 0; i < NCHUNK; i++) step();
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_sum", 64'(o_sum), 64'(vecs[3].sum));
      chk("hold_cout", 64'(o_cout), 64'(vecs[3].cout));
      chk("hold_ready", 64'(o_ready), 64'd0);
      if (i < 3) step();
    end
    rdy_val = 1'b1;
    wait_empty(20);
    chk("hold_released", 64'(o_valid), 64'd0);

    // i_valid held high across two back-to-back operations.
    r0 = n_results;
    accepts = 0;
    i_add_term1 = 48'hAAAAAAAAAAAA;
    i_add_term2 = 48'h555555555555;
    i_cin       = 1'b1;
    i_valid     = 1'b1;
    for (int c = 0; c < 40 && accepts < 2; c++) begin
      if (o_ready) begin
        sb_q.push_back(model(i_add_term1, i_add_term2, i_cin));
        n_pushed++;
        acc_cyc[accepts] = cyc;
        accepts++;
        step();
        if (accepts == 1) begin
          i_add_term1 = 48'h000FFF000FFF;
          i_add_term2 = 48'h000001000001;
          i_cin       = 1'b0;
        end else begin
          i_valid = 1'b0;
        end
      end else begin
        step();
      end
    end
    chk("b2b_accepts", 64'(accepts), 64'd2);
    if (accepts == 2) chk("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NCHUNK + 2));
    wait_empty(50);
    chk("b2b_results", 64'(n_results - r0), 64'd2);

    // Reset during the second RUN cycle abandons the operation.
    send(48'h000000000111, 48'h000000000222, 1'b0, 1'b0, '0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run_ready", 64'(o_ready), 64'd1);
    chk("rst_run_valid", 64'(o_valid), 64'd0);
    chk("rst_run_busy", 64'(o_busy), 64'd0);
    chk("rst_run_sum", 64'(o_sum), 64'd0);
    seen = 0;
    for (int i = 0; i < NCHUNK + 4; i++) begin
      if (o_valid) seen++;
      step();
    end
    chk("rst_no_valid", 64'(seen), 64'd0);
    send(48'd5, 48'd7, 1'b0, 1'b1, {1'b0, 48'h00000000000C});
    wait_empty(50);

    // Randomised regression with random i_ready back-pressure.
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      t64 = {$urandom(), $urandom()};
      ra  = t64[W-1:0];
      t64 = {$urandom(), $urandom()};
      rb  = t64[W-1:0];
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b1, model(ra, rb, rc));
    end
    wait_empty(500);
    bp_en = 1'b0;
    chk("result_count", 64'(n_results), 64'(n_pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
